// File: rtl/bean_spawner_pkg.sv
// Shared game constants, FSM encoding and LFSR helper for the bean spawner.
package bean_spawner_pkg;

  localparam int unsigned POS_W = 11;
  localparam int unsigned LFSR_W = 16;

  localparam logic [POS_W-1:0] POS_MAX = '1;
  localparam logic [POS_W-1:0] X0_INIT = 11'd200;
  localparam logic [POS_W-1:0] X1_INIT = 11'd450;
  localparam logic [POS_W-1:0] X2_INIT = 11'd750;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bean_lfsr.sv
// Spacing LFSR; advances 'step' times per clock so several respawns can share one tick.
module bean_lfsr
  import bean_spawner_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        step,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] value_nxt;

  always_comb begin
    value_nxt = value;
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < step) value_nxt = lfsr_next(value_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) value <= LFSR_SEED;
    else       value <= value_nxt;
  end

endmodule

// File: rtl/bean_spawner.sv
// Scrolls three beans left once per game tick and respawns them behind the furthest one.
module bean_spawner
  import bean_spawner_pkg::*;
#(
  parameter int unsigned TICK_DIV = 833333,
  parameter int unsigned SHIFT    = 5,
  parameter int unsigned MIN_GAP  = 400
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             collide,
  output logic [POS_W-1:0] bean_x0,
  output logic [POS_W-1:0] bean_x1,
  output logic [POS_W-1:0] bean_x2,
  output logic             tick,
  output logic [15:0]      pass_count,
  output logic             halted
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SUM_W = POS_W + 2;

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [POS_W-1:0]   pos      [3];
  logic [POS_W-1:0]   pos_nxt  [3];
  logic [POS_W-1:0]   furthest;
  logic [POS_W-1:0]   furthest_nxt;
  logic [POS_W-1:0]   f_work;
  logic [LFSR_W-1:0]  lfsr_value;
  logic [LFSR_W-1:0]  lfsr_work;
  logic [SUM_W-1:0]   sum;
  logic [1:0]         n_resp;
  logic [1:0]         lfsr_step;
  logic               update;

  assign tick    = (state == ST_RUN) && (cnt == CNT_W'(TICK_DIV - 1));
  assign update  = tick && !collide;
  assign bean_x0 = pos[0];
  assign bean_x1 = pos[1];
  assign bean_x2 = pos[2];

  assign lfsr_step = update ? n_resp : 2'd0;

  bean_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (lfsr_step),
    .value (lfsr_value)
  );

  // Lowest index respawns first; later respawns see its furthest and advanced LFSR
  always_comb begin
    f_work    = furthest;
    lfsr_work = lfsr_value;
    sum       = '0;
    n_resp    = '0;
    for (int i = 0; i < 3; i++) begin
      pos_nxt[i] = pos[i] - POS_W'(SHIFT);
      if (pos[i] <= POS_W'(SHIFT)) begin
        sum = SUM_W'(f_work) - SUM_W'(SHIFT) + SUM_W'(MIN_GAP) + SUM_W'(lfsr_work[7:0]);
        pos_nxt[i] = (sum > SUM_W'(POS_MAX)) ? POS_MAX : sum[POS_W-1:0];
        f_work     = pos_nxt[i];
        lfsr_work  = lfsr_next(lfsr_work);
        n_resp     = n_resp + 2'd1;
      end
    end
    furthest_nxt = (n_resp != 2'd0) ? f_work : furthest - POS_W'(SHIFT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pos[0]     <= X0_INIT;
      pos[1]     <= X1_INIT;
      pos[2]     <= X2_INIT;
      furthest   <= X2_INIT;
      pass_count <= '0;
      halted     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (run) state <= ST_RUN;
        end
        ST_RUN: begin
          cnt <= tick ? '0 : cnt + CNT_W'(1);
          if (collide) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (!run) begin
            state <= ST_IDLE;
          end
          if (update) begin
            pos        <= pos_nxt;
            furthest   <= furthest_nxt;
            pass_count <= pass_count + 16'(n_resp);
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bean_spawner.sv
// Directed bench for bean_spawner with a 4-cycle game tick.
module tb_bean_spawner;

  localparam int unsigned TDIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        collide = 1'b0;
  logic [10:0] bean_x0, bean_x1, bean_x2;
  logic        tick;
  logic [15:0] pass_count;
  logic        halted;

  int checks = 0;
  int errors = 0;

  bean_spawner #(.TICK_DIV(TDIV), .SHIFT(5), .MIN_GAP(400)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .collide    (collide),
    .bean_x0    (bean_x0),
    .bean_x1    (bean_x1),
    .bean_x2    (bean_x2),
    .tick       (tick),
    .pass_count (pass_count),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; collide = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Runs until n ticks are seen, lets the last update land, then pauses
  task automatic run_ticks(input int n);
    int k = 0;
    int cyc = 0;
    run = 1'b1;
    while (k < n && cyc < n * TDIV * 2 + 10) begin
      step();
      cyc++;
      if (tick) k++;
    end
    checks++;
    if (k !== n) begin
      errors++;
      $display("FAIL run_ticks_budget: got %0d ticks required %0d", k, n);
    end
    step();
    run = 1'b0;
  endtask

  task automatic test_reset();
    int nt = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick) nt++;
    end
    checks += 6;
    if (nt !== 0) begin errors++; $display("FAIL reset_ticks: got %0d required 0", nt); end
    if (bean_x0 !== 11'd200) begin errors++; $display("FAIL reset_x0: got %0d required 200", bean_x0); end
    if (bean_x1 !== 11'd450) begin errors++; $display("FAIL reset_x1: got %0d required 450", bean_x1); end
    if (bean_x2 !== 11'd750) begin errors++; $display("FAIL reset_x2: got %0d required 750", bean_x2); end
    if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0d required 0", halted); end
    if (pass_count !== 16'd0) begin errors++; $display("FAIL reset_pass: got %0d required 0", pass_count); end
  endtask

  task automatic test_tick_rate();
    int nt = 0;
    int t1 = 0;
    int t2 = 0;
    do_reset();
    run = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (tick) begin
        nt++;
        if (nt == 1) t1 = i;
        else t2 = i;
      end
    end
    run = 1'b0;
    checks += 6;
    if (nt !== 2) begin errors++; $display("FAIL rate_count: got %0d required 2", nt); end
    if (t1 !== 4) begin errors++; $display("FAIL rate_first: got cycle %0d required 4", t1); end
    if (t2 - t1 !== 4) begin errors++; $display("FAIL rate_spacing: got %0d required 4", t2 - t1); end
    if (bean_x0 !== 11'd190) begin errors++; $display("FAIL rate_x0: got %0d required 190", bean_x0); end
    if (bean_x1 !== 11'd440) begin errors++; $display("FAIL rate_x1: got %0d required 440", bean_x1); end
    if (bean_x2 !== 11'd740) begin errors++; $display("FAIL rate_x2: got %0d required 740", bean_x2); end
  endtask

  task automatic test_first_respawn();
    do_reset();
    run_ticks(40);
    checks += 4;
    if (bean_x0 !== 11'd1175) begin errors++; $display("FAIL respawn_x0: got %0d required 1175", bean_x0); end
    if (bean_x1 !== 11'd250) begin errors++; $display("FAIL respawn_x1: got %0d required 250", bean_x1); end
    if (bean_x2 !== 11'd550) begin errors++; $display("FAIL respawn_x2: got %0d required 550", bean_x2); end
    if (pass_count !== 16'd1) begin errors++; $display("FAIL respawn_pass: got %0d required 1", pass_count); end
  endtask

  task automatic test_pause();
    int nt = 0;
    int t1 = 0;
    int t2 = 0;
    do_reset();
    run = 1'b1;
    step();
    step();
    run = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step();
      if (tick) nt++;
    end
    checks += 2;
    if (nt !== 0) begin errors++; $display("FAIL pause_ticks: got %0d required 0", nt); end
    if (bean_x0 !== 11'd200) begin errors++; $display("FAIL pause_x0: got %0d required 200", bean_x0); end
    nt = 0;
    run = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (tick) begin
        nt++;
        if (nt == 1) t1 = i;
        else t2 = i;
      end
    end
    run = 1'b0;
    checks += 4;
    if (nt !== 2) begin errors++; $display("FAIL resume_count: got %0d required 2", nt); end
    if (t1 !== 2) begin errors++; $display("FAIL resume_first: got cycle %0d required 2", t1); end
    if (t2 !== 6) begin errors++; $display("FAIL resume_second: got cycle %0d required 6", t2); end
    if (bean_x0 !== 11'd190) begin errors++; $display("FAIL resume_x0: got %0d required 190", bean_x0); end
  endtask

  task automatic test_collision();
    int nt = 0;
    int cyc = 0;
    do_reset();
    run_ticks(3);
    run = 1'b1;
    while (!tick && cyc < 10) begin
      step();
      cyc++;
    end
    checks++;
    if (tick !== 1'b1) begin errors++; $display("FAIL collide_wait_tick: got %0d required 1", tick); end
    // Collide in the tick cycle together with run dropping: collide wins
    collide = 1'b1;
    run = 1'b0;
    step();
    collide = 1'b0;
    checks += 4;
    if (halted !== 1'b1) begin errors++; $display("FAIL collide_halted: got %0d required 1", halted); end
    if (bean_x0 !== 11'd185) begin errors++; $display("FAIL collide_x0: got %0d required 185", bean_x0); end
    if (bean_x1 !== 11'd435) begin errors++; $display("FAIL collide_x1: got %0d required 435", bean_x1); end
    if (bean_x2 !== 11'd735) begin errors++; $display("FAIL collide_x2: got %0d required 735", bean_x2); end
    for (int i = 0; i < 20; i++) begin
      run = (i % 3) != 0;
      step();
      if (tick) nt++;
    end
    run = 1'b0;
    checks += 4;
    if (nt !== 0) begin errors++; $display("FAIL halt_ticks: got %0d required 0", nt); end
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %0d required 1", halted); end
    if (bean_x0 !== 11'd185) begin errors++; $display("FAIL halt_x0: got %0d required 185", bean_x0); end
    if (pass_count !== 16'd0) begin errors++; $display("FAIL halt_pass: got %0d required 0", pass_count); end
    do_reset();
    checks += 2;
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset: got %0d required 0", halted); end
    if (bean_x0 !== 11'd200) begin errors++; $display("FAIL halt_reset_x0: got %0d required 200", bean_x0); end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    do_reset();
    run_ticks(99);
    checks += 4;
    if (bean_x0 !== 11'd880) begin errors++; $display("FAIL mid_x0: got %0d required 880", bean_x0); end
    if (bean_x1 !== 11'd1475) begin errors++; $display("FAIL mid_x1: got %0d required 1475", bean_x1); end
    if (bean_x2 !== 11'd255) begin errors++; $display("FAIL mid_x2: got %0d required 255", bean_x2); end
    if (pass_count !== 16'd2) begin errors++; $display("FAIL mid_pass: got %0d required 2", pass_count); end
    run = 1'b1;
    while (!tick && cyc < 10) begin
      step();
      cyc++;
    end
    checks++;
    if (tick !== 1'b1) begin errors++; $display("FAIL mid_wait_tick: got %0d required 1", tick); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    run = 1'b0;
    checks += 6;
    if (bean_x0 !== 11'd200) begin errors++; $display("FAIL midrst_x0: got %0d required 200", bean_x0); end
    if (bean_x1 !== 11'd450) begin errors++; $display("FAIL midrst_x1: got %0d required 450", bean_x1); end
    if (bean_x2 !== 11'd750) begin errors++; $display("FAIL midrst_x2: got %0d required 750", bean_x2); end
    if (pass_count !== 16'd0) begin errors++; $display("FAIL midrst_pass: got %0d required 0", pass_count); end
    if (tick !== 1'b0) begin errors++; $display("FAIL midrst_tick: got %0d required 0", tick); end
    if (halted !== 1'b0) begin errors++; $display("FAIL midrst_halted: got %0d required 0", halted); end
    // Seed and furthest must be restored: the first respawn repeats exactly
    run_ticks(40);
    checks += 2;
    if (bean_x0 !== 11'd1175) begin errors++; $display("FAIL midrst_respawn_x0: got %0d required 1175", bean_x0); end
    if (pass_count !== 16'd1) begin errors++; $display("FAIL midrst_respawn_pass: got %0d required 1", pass_count); end
  endtask

  initial begin
    test_reset();
    test_tick_rate();
    test_first_respawn();
    test_pause();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
